// File: rtl/mac_seq.sv
// mac_seq: sequential unsigned dot-product MAC; define MAC_SEQ_SAT_EN to saturate on overflow instead of wrapping
module mac_seq #(
  parameter int WIDTH_A = 5,
  parameter int WIDTH_B = 7,
  parameter int LEN_W = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [LEN_W-1:0]           len,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH_A-1:0]         A,
  input  logic [WIDTH_B-1:0]         B,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH_A+WIDTH_B-1:0] result,
  output logic                       overflow,
  output logic                       busy
);
  localparam int W = WIDTH_A + WIDTH_B;
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
  state_t state, state_n;
  logic [W-1:0] acc, acc_n, prod, acc_step;
  logic [LEN_W-1:0] cnt, cnt_n;
  logic ovf, ovf_n;
  logic [W:0] sum;
  logic fire;
  assign in_ready = state == ACCUM;
  assign out_valid = state == DONE;
  assign busy = state != IDLE;
  assign result = acc;
  assign overflow = ovf;
  assign fire = in_valid && in_ready;
  assign prod = W'(A) * W'(B);
  assign sum = {1'b0, acc} + {1'b0, prod};
`ifdef MAC_SEQ_SAT_EN
  assign acc_step = sum[W] ? '1 : sum[W-1:0];
`else
  assign acc_step = sum[W-1:0];
`endif
  always_comb begin
    state_n = state;
    acc_n = acc;
    cnt_n = cnt;
    ovf_n = ovf;
    case (state)
      IDLE: if (start) begin
        acc_n = '0;
        ovf_n = 1'b0;
        cnt_n = len;
        state_n = (len != '0) ? ACCUM : DONE;
      end
      ACCUM: if (fire) begin
        acc_n = acc_step;
        ovf_n = ovf | sum[W];
        cnt_n = cnt - LEN_W'(1);
        state_n = (cnt == LEN_W'(1)) ? DONE : ACCUM;
      end
      DONE: state_n = out_ready ? IDLE : DONE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else begin
      state <= state_n;
      acc <= acc_n;
      cnt <= cnt_n;
      ovf <= ovf_n;
    end
  end
endmodule

// File: tb/tb_mac_seq.sv
// tb_mac_seq: directed and random dot-product runs checked against a scoreboard of expected results
module tb_mac_seq;
  localparam int W = 12;
  logic clk = 1'b0;
  logic rst, start, in_valid, in_ready, out_valid, out_ready, overflow, busy;
  logic [3:0] len;
  logic [4:0] A;
  logic [6:0] B;
  logic [W-1:0] result;
  int n_cmp = 0;
  int n_err = 0;
  int m_acc, m_rem;
  logic m_ovf;
  logic [W:0] sb[$];
  logic [W:0] front;

  mac_seq dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic begin_run(input int l);
    start = 1'b1;
    len = 4'(l);
    m_acc = 0;
    m_ovf = 1'b0;
    m_rem = l;
    step();
    start = 1'b0;
    if (l == 0) sb.push_back({1'b0, W'(0)});
  endtask

  task automatic feed(input int a, input int b, input bit v);
    int s;
    bit hs;
    A = 5'(a);
    B = 7'(b);
    in_valid = v;
    chk("in_ready", in_ready, m_rem != 0);
    hs = v && m_rem != 0;
    step();
    in_valid = 1'b0;
    if (hs) begin
      s = m_acc + a * b;
      if (s > 4095) m_ovf = 1'b1;
`ifdef MAC_SEQ_SAT_EN
      m_acc = (s > 4095) ? 4095 : s;
`else
      m_acc = s % 4096;
`endif
      m_rem--;
      if (m_rem == 0) sb.push_back({m_ovf, W'(m_acc)});
    end
  endtask

  task automatic pop_check(input string tag);
    int k;
    for (k = 0; k < 16 && !out_valid; k++) step();
    chk({tag, "_timeout"}, out_valid, 1);
    if (sb.size() == 0) begin
      chk({tag, "_sb_nonempty"}, 0, 1);
    end else begin
      front = sb.pop_front();
      chk({tag, "_result"}, result, front[W-1:0]);
      chk({tag, "_overflow"}, overflow, front[W]);
    end
    out_ready = 1'b1;
    start = 1'b1;
    len = 4'd3;
    step();
    out_ready = 1'b0;
    start = 1'b0;
    chk({tag, "_idle"}, busy, 0);
    chk({tag, "_ov_low"}, out_valid, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0; out_ready = 1'b0; A = '0; B = '0;
    m_rem = 0;
    step();
    rst = 1'b0;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_result", result, 0);
    chk("rst_overflow", overflow, 0);

    begin_run(2);
    chk("t1_busy", busy, 1);
    feed(13, 23, 1);
    feed(15, 21, 1);
    chk("t1_latency", out_valid, 1);
    pop_check("t1");

    begin_run(2);
    feed(31, 127, 1);
    feed(31, 127, 1);
    pop_check("t2");

    begin_run(0);
    chk("t3_out_valid", out_valid, 1);
    chk("t3_in_ready", in_ready, 0);
    pop_check("t3");

    begin_run(3);
    feed(3, 4, 1);
    feed(9, 9, 0);
    feed(9, 9, 0);
    feed(5, 6, 1);
    feed(9, 9, 0);
    feed(7, 2, 1);
    for (int i = 0; i < 5; i++) begin
      front = sb.size() != 0 ? sb[0] : '0;
      start = (i == 2);
      len = 4'd2;
      chk("t4_hold_valid", out_valid, 1);
      chk("t4_hold_result", result, front[W-1:0]);
      chk("t4_hold_in_ready", in_ready, 0);
      step();
      start = 1'b0;
    end
    pop_check("t4");

    begin_run(3);
    feed(5, 5, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    m_rem = 0;
    chk("t5_busy", busy, 0);
    chk("t5_out_valid", out_valid, 0);
    begin_run(1);
    feed(2, 3, 1);
    pop_check("t5");

    for (int r = 0; r < 4; r++) begin
      begin_run(int'($urandom_range(1, 6)));
      for (int c = 0; c < 40 && m_rem != 0; c++)
        feed(int'($urandom_range(0, 31)), int'($urandom_range(0, 127)), bit'($urandom_range(0, 1)));
      pop_check("rnd");
    end

    chk("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
